// File: rtl/tinyalu_arbiter_if.sv
// Requester and TinyALU pin bundle for tinyalu_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/ALU environment side.
interface tinyalu_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_result;
  logic                 rsp_err;
  logic                 busy;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic [2:0]           alu_op;
  logic                 alu_start;
  logic                 alu_reset_n;
  logic                 alu_done;
  logic [15:0]          alu_result;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_done, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, busy,
           alu_a, alu_b, alu_op, alu_start, alu_reset_n
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_done, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, busy,
           alu_a, alu_b, alu_op, alu_start, alu_reset_n
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU between NUM_REQ requesters.
// Optional macro TINYALU_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog that resets the ALU and reports an error.
module tinyalu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  tinyalu_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_RST = 3'b111;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("tinyalu_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RST_ALU,
    RESPOND
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic [2:0]         r_op;
  logic               r_rst_cnt;
  logic               r_err_pend;

  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [15:0]        r_rsp_result;
  logic               r_rsp_err;
  logic               r_busy;
  logic [7:0]         r_alu_a;
  logic [7:0]         r_alu_b;
  logic [2:0]         r_alu_op;
  logic               r_alu_start;
  logic               r_alu_reset_n;

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0]     r_to_cnt;
`endif

  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [7:0]         w_sel_a;
  logic [7:0]         w_sel_b;
  logic [2:0]         w_sel_op;

  // First valid requester at or above the pointer, wrapping, plus its operands.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[IDW'((int'(r_ptr) + k) % NUM_REQ)]) begin
        w_found  = 1'b1;
        w_winner = IDW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_sel_a  = bus.req_a[8*i +: 8];
        w_sel_b  = bus.req_b[8*i +: 8];
        w_sel_op = bus.req_op[3*i +: 3];
      end
    end
  end

  // Response outputs are loaded on the edge that enters RESPOND, so rsp_valid is high during RESPOND.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_id          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_op          <= '0;
      r_rst_cnt     <= 1'b0;
      r_err_pend    <= 1'b0;
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_result  <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_alu_start   <= 1'b0;
      r_alu_reset_n <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_alu_reset_n <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_req_ready[w_winner] <= 1'b1;
            r_id    <= w_winner;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          case (r_op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
              r_alu_a     <= r_a;
              r_alu_b     <= r_b;
              r_alu_op    <= r_op;
              r_alu_start <= 1'b1;
`ifdef TINYALU_ARB_TIMEOUT_EN
              r_to_cnt    <= '0;
`endif
              r_state     <= WAIT_DONE;
            end
            OP_NOP: begin
              r_alu_a            <= r_a;
              r_alu_b            <= r_b;
              r_alu_op           <= r_op;
              r_alu_start        <= 1'b1;
              r_rsp_valid[r_id]  <= 1'b1;
              r_rsp_result       <= '0;
              r_rsp_err          <= 1'b0;
              r_state            <= RESPOND;
            end
            OP_RST: begin
              r_alu_start   <= 1'b0;
              r_alu_op      <= OP_RST;
              r_alu_reset_n <= 1'b0;
              r_rst_cnt     <= 1'b0;
              r_err_pend    <= 1'b0;
              r_state       <= RST_ALU;
            end
            default: begin
              r_rsp_valid[r_id] <= 1'b1;
              r_rsp_result      <= '0;
              r_rsp_err         <= 1'b1;
              r_state           <= RESPOND;
            end
          endcase
        end
        WAIT_DONE: begin
          if (bus.alu_done) begin
            r_alu_start       <= 1'b0;
            r_rsp_valid[r_id] <= 1'b1;
            r_rsp_result      <= bus.alu_result;
            r_rsp_err         <= 1'b0;
            r_state           <= RESPOND;
          end
`ifdef TINYALU_ARB_TIMEOUT_EN
          else if (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
            r_alu_start   <= 1'b0;
            r_alu_reset_n <= 1'b0;
            r_rst_cnt     <= 1'b0;
            r_err_pend    <= 1'b1;
            r_state       <= RST_ALU;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        RST_ALU: begin
          if (!r_rst_cnt) begin
            r_alu_reset_n <= 1'b0;
            r_rst_cnt     <= 1'b1;
          end else begin
            r_rsp_valid[r_id] <= 1'b1;
            r_rsp_result      <= '0;
            r_rsp_err         <= r_err_pend;
            r_state           <= RESPOND;
          end
        end
        RESPOND: begin
          r_alu_start <= 1'b0;
          r_busy      <= 1'b0;
          r_ptr       <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.busy        = r_busy;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_start   = r_alu_start;
  assign bus.alu_reset_n = r_alu_reset_n;
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter: directed cases plus randomized batches against a round-robin/ALU model.
// Builds with or without TINYALU_ARB_TIMEOUT_EN; the DUT is instantiated with TIMEOUT_CYCLES=8.
module tb_tinyalu_arbiter;
  localparam int NREQ = 4;

  logic clk;
  logic reset;

  tinyalu_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  tinyalu_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nTests = 0;
  int nFail  = 0;

  logic [7:0] reqA  [NREQ];
  logic [7:0] reqB  [NREQ];
  logic [2:0] reqOp [NREQ];
  int raiseCnt [NREQ] = '{default: 0};
  int grantCnt [NREQ] = '{default: 0};
  int aluLatency = 1;
  int modelPtr = 0;

  int grantQ [$];
  int grantCyc [$];
  int rspId [$];
  logic [15:0] rspRes [$];
  logic rspErr [$];
  int cycle = 0;
  int startCyc = 0;
  int startRise = 0;
  int rstLowCyc = 0;
  int onehotBad = 0;
  logic prevStart = 1'b0;
  int rid;
  int aluCnt = 0;

  function automatic logic [15:0] refAlu(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic expErr(logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

  // Requester valid stays up from raise until its grant pulse is observed.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = (raiseCnt[i] != grantCnt[i]);
      bus.req_a[8*i +: 8]    = reqA[i];
      bus.req_b[8*i +: 8]    = reqB[i];
      bus.req_op[3*i +: 3]   = reqOp[i];
    end
  end

  // TinyALU stand-in: done rises once start has been high for aluLatency cycles (0 = never).
  always @(negedge clk) begin
    if (!bus.alu_reset_n || !bus.alu_start) begin
      aluCnt = 0;
      bus.alu_done = 1'b0;
      bus.alu_result = 16'h0000;
    end else begin
      aluCnt++;
      if (aluLatency != 0 && aluCnt == aluLatency) begin
        bus.alu_done = 1'b1;
        bus.alu_result = refAlu(bus.alu_a, bus.alu_b, bus.alu_op);
      end else begin
        bus.alu_done = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cycle++;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        grantCnt[i]++;
        grantQ.push_back(i);
        grantCyc.push_back(cycle);
      end
    end
    if ($countones(bus.req_ready) > 1) onehotBad++;
    if (bus.rsp_valid != '0) begin
      if ($countones(bus.rsp_valid) != 1) onehotBad++;
      rid = -1;
      for (int i = 0; i < NREQ; i++) if (bus.rsp_valid[i] && rid < 0) rid = i;
      rspId.push_back(rid);
      rspRes.push_back(bus.rsp_result);
      rspErr.push_back(bus.rsp_err);
    end
    if (bus.alu_start) startCyc++;
    if (bus.alu_start && !prevStart) startRise++;
    prevStart = bus.alu_start;
    if (!bus.alu_reset_n) rstLowCyc++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic raiseReq(input logic [3:0] mask);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) if (mask[i]) raiseCnt[i]++;
  endtask

  task automatic waitResponses(input int base, input int n, input int budget);
    int c = 0;
    while (rspId.size() < base + n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  // Raise a set of requests together; expected grant order comes from the pointer search model.
  task automatic applyStimulus(input logic [3:0] mask, input bit tmo, input string tag);
    int order [$];
    bit pend [NREQ];
    int gB, rB, n;
    gB = grantQ.size();
    rB = rspId.size();
    n = $countones(mask);
    for (int i = 0; i < NREQ; i++) pend[i] = mask[i];
    for (int j = 0; j < n; j++) begin
      bit found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int idx = (modelPtr + k) % NREQ;
        if (!found && pend[idx]) begin
          found = 1'b1;
          pend[idx] = 1'b0;
          order.push_back(idx);
          modelPtr = (idx + 1) % NREQ;
        end
      end
    end
    raiseReq(mask);
    waitResponses(rB, n, 25 * n + 20);
    checkOutput({tag, "_count"}, rspId.size(), rB + n);
    for (int j = 0; j < n; j++) begin
      if (rspId.size() > rB + j && grantQ.size() > gB + j) begin
        checkOutput({tag, "_grant"}, grantQ[gB + j], order[j]);
        checkOutput({tag, "_rspid"}, rspId[rB + j], order[j]);
        checkOutput({tag, "_result"}, rspRes[rB + j],
                    tmo ? 16'h0000 : refAlu(reqA[order[j]], reqB[order[j]], reqOp[order[j]]));
        checkOutput({tag, "_err"}, rspErr[rB + j], tmo ? 1'b1 : expErr(reqOp[order[j]]));
      end
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    modelPtr = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, r, rb, gb;
    for (int i = 0; i < NREQ; i++) begin
      reqA[i] = '0;
      reqB[i] = '0;
      reqOp[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_result", bus.rsp_result, 0);
    checkOutput("rst_rsp_err", bus.rsp_err, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_alu_pins", {bus.alu_a, bus.alu_b, bus.alu_op}, 0);
    checkOutput("rst_alu_start", bus.alu_start, 0);
    checkOutput("rst_alu_reset_n", bus.alu_reset_n, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_alu_reset_n", bus.alu_reset_n, 1);

    // Round robin from pointer 0, then a partial re-request.
    aluLatency = 1;
    for (int i = 0; i < NREQ; i++) begin
      reqA[i] = 8'(i);
      reqB[i] = 8'h01;
      reqOp[i] = 3'b001;
    end
    gb = grantCyc.size();
    applyStimulus(4'b1111, 1'b0, "rr_all");
    if (grantCyc.size() > gb + 1) checkOutput("rr_spacing", grantCyc[gb + 1] - grantCyc[gb], 4);
    applyStimulus(4'b0011, 1'b0, "rr_pair");

    // Single add.
    reqA[0] = 8'h12;
    reqB[0] = 8'h34;
    s = startCyc;
    gb = grantCnt[0];
    applyStimulus(4'b0001, 1'b0, "add");
    checkOutput("add_grants", grantCnt[0] - gb, 1);
    checkOutput("add_start_cycles", startCyc - s, 1);
    checkOutput("add_value", rspRes[rspRes.size() - 1], 16'h0046);

    // Slow mul.
    aluLatency = 3;
    reqA[1] = 8'hFF;
    reqB[1] = 8'hFF;
    reqOp[1] = 3'b100;
    s = startCyc;
    r = startRise;
    applyStimulus(4'b0010, 1'b0, "mul");
    checkOutput("mul_start_cycles", startCyc - s, 3);
    checkOutput("mul_start_rises", startRise - r, 1);
    checkOutput("mul_value", rspRes[rspRes.size() - 1], 16'hFE01);
    @(negedge clk);
    checkOutput("mul_busy_after", bus.busy, 0);

    // no_op, rst_op and an illegal opcode.
    aluLatency = 1;
    reqOp[2] = 3'b000;
    s = startCyc;
    applyStimulus(4'b0100, 1'b0, "noop");
    checkOutput("noop_start_cycles", startCyc - s, 1);
    reqOp[3] = 3'b111;
    s = startCyc;
    r = rstLowCyc;
    applyStimulus(4'b1000, 1'b0, "rstop");
    checkOutput("rstop_reset_low", rstLowCyc - r, 2);
    checkOutput("rstop_start_cycles", startCyc - s, 0);
    reqOp[0] = 3'b101;
    s = startCyc;
    r = rstLowCyc;
    applyStimulus(4'b0001, 1'b0, "illegal");
    checkOutput("illegal_start_cycles", startCyc - s, 0);
    checkOutput("illegal_reset_low", rstLowCyc - r, 0);
    checkOutput("illegal_alu_op", bus.alu_op, 3'b111);

    // Randomized batches.
    for (int t = 0; t < 25; t++) begin
      aluLatency = $urandom_range(1, 4);
      for (int i = 0; i < NREQ; i++) begin
        reqA[i] = 8'($urandom);
        reqB[i] = 8'($urandom);
        reqOp[i] = 3'($urandom_range(0, 7));
      end
      applyStimulus(4'($urandom_range(1, 15)), 1'b0, "rand");
    end

    // Reset during WAIT_DONE: no response, pointer restarts at 0.
    aluLatency = 1;
    reqOp[2] = 3'b001;
    applyStimulus(4'b0100, 1'b0, "pre_abort");
    aluLatency = 0;
    reqA[2] = 8'hFF;
    reqB[2] = 8'hFF;
    reqOp[2] = 3'b100;
    rb = rspId.size();
    raiseReq(4'b0100);
    repeat (6) @(negedge clk);
    checkOutput("abort_busy", bus.busy, 1);
    checkOutput("abort_start_held", bus.alu_start, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_start", bus.alu_start, 0);
    checkOutput("abort_reset_n", bus.alu_reset_n, 0);
    checkOutput("abort_busy_cleared", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_reset_n_back", bus.alu_reset_n, 1);
    repeat (3) @(negedge clk);
    checkOutput("abort_no_rsp", rspId.size(), rb);
    modelPtr = 0;
    aluLatency = 1;
    reqOp[1] = 3'b001;
    reqOp[3] = 3'b011;
    applyStimulus(4'b1010, 1'b0, "post_abort");

    // Stuck ALU.
    aluLatency = 0;
    reqOp[0] = 3'b001;
`ifdef TINYALU_ARB_TIMEOUT_EN
    s = startCyc;
    r = rstLowCyc;
    applyStimulus(4'b0001, 1'b1, "timeout");
    checkOutput("timeout_start_cycles", startCyc - s, 8);
    checkOutput("timeout_reset_low", rstLowCyc - r, 2);
`else
    rb = rspId.size();
    raiseReq(4'b0001);
    repeat (40) @(negedge clk);
    checkOutput("stuck_busy", bus.busy, 1);
    checkOutput("stuck_start", bus.alu_start, 1);
    checkOutput("stuck_no_rsp", rspId.size(), rb);
    pulseReset();
`endif
    aluLatency = 1;
    applyStimulus(4'b0001, 1'b0, "recover");

    checkOutput("onehot_outputs", onehotBad, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
